// File: rtl/fetch_pkg.sv
// Shared defaults and entry layout for the instruction fetch queue.
// Latency: n/a (types and parameters only).
// Backpressure: n/a.
package fetch_pkg;
    localparam int PC_W_DEF   = 6;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 4;

    typedef struct packed {
        logic [PC_W_DEF-1:0]   pc;
        logic [DATA_W_DEF-1:0] instr;
    } entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush, occupancy count and registered head.
// Latency: a push becomes visible at the head after the next edge (no fall-through).
// Backpressure: caller must not push when full unless popping in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = $bits(entry_t),
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         push_dat,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_dat = mem[rd_ptr];
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the PC, reads imem combinationally, buffers {pc, instr} for the decoder.
// Latency: word fetched on edge N is presented from cycle N+1; redirect costs a 2-cycle bubble.
// Backpressure: out_ready=0 fills the buffer, then the PC holds until a pop frees a slot.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int PC_W   = PC_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    output logic [PC_W-1:0]          imem_addr,
    input  logic [DATA_W-1:0]        imem_data,
    input  logic                     redirect_valid,
    input  logic [PC_W-1:0]          redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_instr,
    output logic [PC_W-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int ENTRY_W = PC_W + DATA_W;

    logic [PC_W-1:0]    pc;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] head_dat;

    // A head shown during a redirect is never considered transferred.
    assign pop  = out_valid & out_ready & ~redirect_valid;
    assign push = enable & ~redirect_valid & (~full | pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              pc <= '0;
        else if (redirect_valid) pc <= redirect_pc;
        else if (push)           pc <= pc + 1'b1;
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .flush    (redirect_valid),
        .push_dat ({pc, imem_data}),
        .head_dat (head_dat),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    assign imem_addr = pc;
    assign out_valid = ~empty;
    assign out_pc    = out_valid ? head_dat[ENTRY_W-1:DATA_W] : '0;
    assign out_instr = out_valid ? head_dat[DATA_W-1:0] : '0;
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: imem returns 0xA000_0000 + address.
module tb_instr_fetch_queue;
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [5:0]  redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [5:0]  out_pc;
    logic [2:0]  count;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign imem_data = 32'hA000_0000 | {26'd0, imem_addr};

    instr_fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .count          (count)
    );

    task automatic test_reset();
        reset = 1'b0; enable = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid got %b want 0", out_valid); end
        n_cmp++; if (count !== 3'd0)      begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_cmp++; if (imem_addr !== 6'd0)  begin n_fail++; $display("FAIL reset_addr got %0d want 0", imem_addr); end
        n_cmp++; if (out_instr !== 32'd0) begin n_fail++; $display("FAIL reset_instr got %h want 0", out_instr); end
        n_cmp++; if (out_pc !== 6'd0)     begin n_fail++; $display("FAIL reset_pc got %0d want 0", out_pc); end
    endtask

    task automatic test_stream();
        reset = 1'b1; enable = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_first_valid got %b want 1", out_valid); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_cmp++; if (out_pc !== 6'(i) || out_instr !== (32'hA000_0000 + 32'(i)) || count !== 3'd1)
                begin n_fail++; $display("FAIL stream[%0d] got pc=%0d instr=%h cnt=%0d want pc=%0d instr=%h cnt=1",
                    i, out_pc, out_instr, count, i, 32'hA000_0000 + 32'(i)); end
            @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_fill_drain();
        redirect_valid = 1'b1; redirect_pc = 6'd0; out_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0 || count !== 3'd0)
            begin n_fail++; $display("FAIL fill_flush got valid=%b cnt=%0d want 0/0", out_valid, count); end
        redirect_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_cmp++; if (count !== 3'd4)     begin n_fail++; $display("FAIL fill_count got %0d want 4", count); end
        n_cmp++; if (imem_addr !== 6'd4) begin n_fail++; $display("FAIL fill_addr got %0d want 4", imem_addr); end
        n_cmp++; if (out_pc !== 6'd0 || out_instr !== 32'hA000_0000)
            begin n_fail++; $display("FAIL fill_stable got pc=%0d instr=%h want 0/a0000000", out_pc, out_instr); end
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_cmp++; if (out_pc !== 6'(i) || count !== 3'd4)
                begin n_fail++; $display("FAIL drain[%0d] got pc=%0d cnt=%0d want pc=%0d cnt=4", i, out_pc, count, i); end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        enable = 1'b0;
        @(negedge clk);
        n_cmp++; if (count !== 3'd3 || out_pc !== 6'd9)
            begin n_fail++; $display("FAIL stall_pop got cnt=%0d pc=%0d want 3/9", count, out_pc); end
        n_cmp++; if (imem_addr !== 6'd12) begin n_fail++; $display("FAIL stall_hold got %0d want 12", imem_addr); end
        enable = 1'b1; redirect_valid = 1'b1; redirect_pc = 6'h20;
        @(negedge clk);
        redirect_valid = 1'b0;
        n_cmp++; if (count !== 3'd0 || out_valid !== 1'b0)
            begin n_fail++; $display("FAIL redir_flush got cnt=%0d valid=%b want 0/0", count, out_valid); end
        n_cmp++; if (imem_addr !== 6'h20) begin n_fail++; $display("FAIL redir_addr got %0d want 32", imem_addr); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== 6'h20 || out_instr !== 32'hA000_0020)
            begin n_fail++; $display("FAIL redir_target got valid=%b pc=%0d instr=%h want 1/32/a0000020",
                out_valid, out_pc, out_instr); end
    endtask

    task automatic test_wrap();
        logic [5:0] exp_pc [4];
        exp_pc[0] = 6'd62; exp_pc[1] = 6'd63; exp_pc[2] = 6'd0; exp_pc[3] = 6'd1;
        redirect_valid = 1'b1; redirect_pc = 6'd62; out_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid !== 1'b1 || out_pc !== exp_pc[i])
                begin n_fail++; $display("FAIL wrap[%0d] got valid=%b pc=%0d want 1/%0d", i, out_valid, out_pc, exp_pc[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        redirect_valid = 1'b1; redirect_pc = 6'd10; out_ready = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL arst_setup got cnt=%0d want 2", count); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || count !== 3'd0 || imem_addr !== 6'd0)
            begin n_fail++; $display("FAIL arst_immediate got valid=%b cnt=%0d addr=%0d want 0/0/0",
                out_valid, count, imem_addr); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_pc !== 6'd0)
            begin n_fail++; $display("FAIL arst_release got valid=%b pc=%0d want 0/0", out_valid, out_pc); end
        @(negedge clk);
        n_cmp++; if (out_pc !== 6'd0 || out_instr !== 32'hA000_0000)
            begin n_fail++; $display("FAIL arst_restart got pc=%0d instr=%h want 0/a0000000", out_pc, out_instr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_drain();
        test_redirect();
        test_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
